hygro_convert: RTL and testbench

//  Downstream stage of the Pmod HYGRO interface. Captures the raw 14-bit temperature
//  and humidity words when the interface pulses its new-data strobe, then scales them
//  to hundredths of degC and hundredths of %RH using a sequential shift-add multiplier.

---
 rtl/hygro_convert.sv | 151 +++++++++++++++
 tb/tb_hygro_convert.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/hygro_convert.sv
// rtl/hygro_convert.sv - HYGRO raw-word scaling to x100 units with packed BCD results
module hygro_convert #(
    parameter int T_SCALE  = 16500,
    parameter int T_OFFSET = 4000,
    parameter int H_SCALE  = 10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_data,
    input  logic [13:0] tem,
    input  logic [13:0] hum,
    output logic        busy,
    output logic        data_valid,
    output logic        overrun,
    output logic        tem_neg,
    output logic [19:0] tem_bcd,
    output logic [15:0] hum_bcd
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MUL_T  = 3'd1,
        MUL_H  = 3'd2,
        OFFSET = 3'd3,
        BCD    = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [29:0] T_SCALE_W  = 30'(T_SCALE);
    localparam logic [29:0] H_SCALE_W  = 30'(H_SCALE);
    localparam logic [15:0] T_OFFSET_W = 16'(T_OFFSET);

    state_t      state, next_state;
    logic [3:0]  cnt;
    logic [13:0] tem_r, hum_r;
    logic [29:0] acc_t, acc_h;
    logic [13:0] bin_t, bin_h;
    logic [19:0] bcd_t;
    logic [15:0] bcd_h;
    logic        neg_r;
    logic [15:0] t_floor;

    assign t_floor = acc_t[29:14];

    function automatic logic [19:0] adj20(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int i = 0; i < 5; i++)
            if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        return r;
    endfunction

    function automatic logic [15:0] adj16(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++)
            if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (new_data) next_state = MUL_T;
            MUL_T:   if (cnt == 4'd13) next_state = MUL_H;
            MUL_H:   if (cnt == 4'd13) next_state = OFFSET;
            OFFSET:  next_state = BCD;
            BCD:     if (cnt == 4'd13) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // cnt restarts at 0 on every state entry, so it doubles as the multiplier bit weight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            tem_r      <= '0;
            hum_r      <= '0;
            acc_t      <= '0;
            acc_h      <= '0;
            bin_t      <= '0;
            bin_h      <= '0;
            bcd_t      <= '0;
            bcd_h      <= '0;
            neg_r      <= 1'b0;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            tem_neg    <= 1'b0;
            tem_bcd    <= '0;
            hum_bcd    <= '0;
        end else begin
            cnt        <= (state == IDLE || next_state != state) ? 4'd0 : cnt + 4'd1;
            data_valid <= 1'b0;
            overrun    <= new_data && (state != IDLE);

            if (state == IDLE && new_data) busy <= 1'b1;
            else if (data_valid)           busy <= 1'b0;

            case (state)
                IDLE: begin
                    if (new_data) begin
                        tem_r <= tem;
                        hum_r <= hum;
                        acc_t <= '0;
                        acc_h <= '0;
                    end
                end
                MUL_T: begin
                    if (tem_r[0]) acc_t <= acc_t + (T_SCALE_W << cnt);
                    tem_r <= tem_r >> 1;
                end
                MUL_H: begin
                    if (hum_r[0]) acc_h <= acc_h + (H_SCALE_W << cnt);
                    hum_r <= hum_r >> 1;
                end
                OFFSET: begin
                    // exactly T_OFFSET takes the >= branch so zero reports as positive
                    if (t_floor >= T_OFFSET_W) begin
                        bin_t <= 14'(t_floor - T_OFFSET_W);
                        neg_r <= 1'b0;
                    end else begin
                        bin_t <= 14'(T_OFFSET_W - t_floor);
                        neg_r <= 1'b1;
                    end
                    bin_h <= acc_h[27:14];
                    bcd_t <= '0;
                    bcd_h <= '0;
                end
                BCD: begin
                    {bcd_t, bin_t} <= {adj20(bcd_t), bin_t} << 1;
                    {bcd_h, bin_h} <= {adj16(bcd_h), bin_h} << 1;
                end
                DONE: begin
                    tem_neg    <= neg_r;
                    tem_bcd    <= bcd_t;
                    hum_bcd    <= bcd_h;
                    data_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hygro_convert.sv
// tb/tb_hygro_convert.sv - directed self-checking bench for hygro_convert
module tb_hygro_convert;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_data;
    logic [13:0] tem;
    logic [13:0] hum;
    logic        busy;
    logic        data_valid;
    logic        overrun;
    logic        tem_neg;
    logic [19:0] tem_bcd;
    logic [15:0] hum_bcd;

    int checks = 0;
    int errors = 0;
    int dv_seen;

    hygro_convert dut (
        .clk        (clk),
        .rst        (rst),
        .new_data   (new_data),
        .tem        (tem),
        .hum        (hum),
        .busy       (busy),
        .data_valid (data_valid),
        .overrun    (overrun),
        .tem_neg    (tem_neg),
        .tem_bcd    (tem_bcd),
        .hum_bcd    (hum_bcd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge; the next edge is the capture edge (edge 0)
    task automatic start(input logic [13:0] t, input logic [13:0] h);
        new_data = 1'b1;
        tem      = t;
        hum      = h;
        @(posedge clk);
        #1;
        new_data = 1'b0;
        tem      = 14'($urandom);
        hum      = 14'($urandom);
        check("busy_rise", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int first_edge, input logic neg,
                             input logic [19:0] tb, input logic [15:0] hb);
        int edges;
        edges = first_edge;
        while (data_valid !== 1'b1 && edges < 120) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, "_latency"}, 32'(edges), 32'd44);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_neg"}, 32'(tem_neg), 32'(neg));
        check({tag, "_tem_bcd"}, 32'(tem_bcd), 32'(tb));
        check({tag, "_hum_bcd"}, 32'(hum_bcd), 32'(hb));
    endtask

    task automatic check_idle(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_dv_clear"}, 32'(data_valid), 32'd0);
        check({tag, "_busy_clear"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst      = 1'b0;
        new_data = 1'b0;
        tem      = '0;
        hum      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dv", 32'(data_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_neg", 32'(tem_neg), 32'd0);
        check("rst_tem_bcd", 32'(tem_bcd), 32'd0);
        check("rst_hum_bcd", 32'(hum_bcd), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        start(14'd0, 14'd0);
        wait_done("zero", 0, 1'b1, 20'h04000, 16'h0000);
        check_idle("zero");

        start(14'd16383, 14'd16383);
        wait_done("full", 0, 1'b0, 20'h12498, 16'h9999);
        check_idle("full");

        start(14'd3972, 14'd0);
        wait_done("t3972", 0, 1'b0, 20'h00000, 16'h0000);
        check_idle("t3972");

        start(14'd3971, 14'd0);
        wait_done("t3971", 0, 1'b1, 20'h00001, 16'h0000);
        check_idle("t3971");

        // New capture in the data_valid cycle is accepted
        start(14'd4096, 14'd8192);
        wait_done("b2b_a", 0, 1'b0, 20'h00125, 16'h5000);
        start(14'd0, 14'd16383);
        check("b2b_no_overrun", 32'(overrun), 32'd0);
        wait_done("b2b_b", 0, 1'b1, 20'h04000, 16'h9999);
        check_idle("b2b_b");

        // Second strobe at edge 10 is dropped and flagged
        start(14'd4096, 14'd8192);
        repeat (9) @(posedge clk);
        #1;
        check("hold_tem_bcd", 32'(tem_bcd), 32'h04000);
        new_data = 1'b1;
        tem      = 14'd16383;
        hum      = 14'd16383;
        @(posedge clk);
        #1;
        new_data = 1'b0;
        check("overrun_pulse", 32'(overrun), 32'd1);
        @(posedge clk);
        #1;
        check("overrun_clear", 32'(overrun), 32'd0);
        wait_done("ovr", 11, 1'b0, 20'h00125, 16'h5000);
        check_idle("ovr");

        // Reset at edge 20 aborts the conversion
        start(14'd16383, 14'd16383);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_tem_bcd", 32'(tem_bcd), 32'd0);
        check("abort_hum_bcd", 32'(hum_bcd), 32'd0);
        dv_seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) rst = 1'b1;
            if (data_valid) dv_seen++;
        end
        check("abort_no_dv", 32'(dv_seen), 32'd0);
        check("abort_idle_busy", 32'(busy), 32'd0);
        start(14'd4096, 14'd8192);
        wait_done("retrig", 0, 1'b0, 20'h00125, 16'h5000);
        check_idle("retrig");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
